// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side drain controller.
package fifo_rd_pkg;
  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] ptr_t;
  typedef logic [1:0] occ_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry circular skid buffer with push/pop/clear and an occupancy count.
module fifo_rd_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output occ_t             occupancy
);
  logic [WIDTH-1:0] mem [BUF_DEPTH];
  ptr_t wr_ptr;
  ptr_t rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      for (int i = 0; i < BUF_DEPTH; i++)
        if (push && wr_ptr == ptr_t'(i)) mem[i] <= push_data;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      occupancy <= occupancy + occ_t'(1);
      else if (pop && !push) occupancy <= occupancy - occ_t'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < BUF_DEPTH; i++)
      if (rd_ptr == ptr_t'(i)) rd_data = mem[i];
  end
endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain for the synchronous FIFO: credit-based read strobe, landing
// buffer and valid/ready output. Optional stats counter under FIFO_RD_STATS_EN.
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy,
  output logic                  underflow_err
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] rd_words
`endif
);
  occ_t occ;
  logic inflight;
  logic land;
  logic pop;

  // Credit counts the word already in flight so the buffer can never overrun;
  // the strobe looks only at registered state, never at m_ready.
  assign fifo_rd_en = rst_n && !fifo_empty && !flush &&
                      (({1'b0, occ} + {2'b00, inflight}) <= 3'd2);
  assign land       = inflight && !fifo_underflow && !flush;
  assign m_valid    = (occ != '0);
  assign pop        = m_valid && m_ready;
  assign occupancy  = occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight && fifo_underflow) underflow_err <= 1'b1;
    end
  end

  fifo_rd_buf #(.WIDTH(FIFO_WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (land),
    .push_data (fifo_data_out),
    .pop       (pop),
    .rd_data   (m_data),
    .occupancy (occ)
  );

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_words <= '0;
    else if (pop && rd_words != '1)
      rd_words <= rd_words + STAT_WIDTH'(1);
  end
`endif
endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: queue-based FIFO and output-buffer reference model,
// directed scenarios plus randomized m_ready.
module tb_fifo_rd_drain;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty = 1'b1;
  logic         fifo_underflow = 1'b0;
  logic [W-1:0] fifo_data_out = '0;
  logic         flush = 1'b0;
  logic         m_ready = 1'b0;
  logic         fifo_rd_en;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic [1:0]   occupancy;
  logic         underflow_err;
`ifdef FIFO_RD_STATS_EN
  logic [15:0]  rd_words;
`endif

  always #5 clk = ~clk;

  fifo_rd_drain #(.FIFO_WIDTH(W), .STAT_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .flush          (flush),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .occupancy      (occupancy),
    .underflow_err  (underflow_err)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_words       (rd_words)
`endif
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_buf[$];
  bit           inflight_m = 0;
  bit           err_m = 0;
  int           cnt_m = 0;
  bit           force_uf = 0;
  logic [W-1:0] next_word = 1;

  int           cyc, n_rd, n_pop, first_pop, last_pop;
  logic [W-1:0] last_val, first_val, cap;
  bit           have_last;
  int           occ_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      next_word++;
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic phase_start();
    cyc = 0; n_rd = 0; n_pop = 0; first_pop = -1; last_pop = -1;
    have_last = 0; first_val = 'x;
  endtask

  // One clock: compare at the falling edge, then advance model and FIFO after the rising edge.
  task automatic cycle();
    bit exp_rd, rd_obs, do_pop, do_land, do_uf;
    @(negedge clk);
    exp_rd  = rst_n && (fifo_q.size() != 0) && !flush &&
              (exp_buf.size() + int'(inflight_m) <= 2);
    rd_obs  = fifo_rd_en;
    chk("rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    chk("m_valid", 32'(m_valid), 32'(exp_buf.size() != 0));
    chk("occupancy", 32'(occupancy), 32'(exp_buf.size()));
    chk("underflow_err", 32'(underflow_err), 32'(err_m));
`ifdef FIFO_RD_STATS_EN
    chk("rd_words", 32'(rd_words), 32'(cnt_m));
`endif
    if (exp_buf.size() != 0) chk("m_data", 32'(m_data), 32'(exp_buf[0]));
    do_pop  = rst_n && (exp_buf.size() != 0) && m_ready;
    do_land = inflight_m && !fifo_underflow && !flush;
    do_uf   = inflight_m && fifo_underflow;
    if (do_pop) begin
      if (have_last) chk("order", 32'(m_data), 32'(last_val) + 32'd1);
      if (first_pop < 0) begin first_pop = cyc; first_val = m_data; end
      last_val = m_data; have_last = 1; last_pop = cyc; n_pop++;
    end
    if (exp_rd) n_rd++;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_buf.delete(); inflight_m = 0; err_m = 0; cnt_m = 0;
    end else begin
      if (do_uf) err_m = 1;
      if (do_pop) cnt_m++;
      if (flush) exp_buf.delete();
      else begin
        if (do_pop) void'(exp_buf.pop_front());
        if (do_land) exp_buf.push_back(fifo_data_out);
      end
      inflight_m = exp_rd;
    end
    if (rd_obs) begin
      if (force_uf || fifo_q.size() == 0) begin
        fifo_data_out = 16'hDEAD; fifo_underflow = 1'b1;
      end else begin
        fifo_data_out = fifo_q.pop_front(); fifo_underflow = 1'b0;
      end
    end else fifo_underflow = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Preloaded 1..8, consumer always ready
    preload(8); m_ready = 1'b1;
    rst_n = 1'b0; cycle(); cycle();
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    rst_n = 1'b1;
    phase_start();
    repeat (12) cycle();
    chk("p1_pops", 32'(n_pop), 32'd8);
    chk("p1_first_pop_cycle", 32'(first_pop), 32'd2);
    chk("p1_span", 32'(last_pop - first_pop), 32'd7);
    chk("p1_first_val", 32'(first_val), 32'd1);
`ifdef FIFO_RD_STATS_EN
    chk("p1_rd_words", 32'(rd_words), 32'd8);
`endif

    // Consumer stalled: credit limit, then drain without gaps
    m_ready = 1'b0; do_reset();
    fifo_q.delete(); next_word = 1; preload(8);
    phase_start();
    repeat (8) cycle();
    chk("p2_reads", 32'(n_rd), 32'd3);
    chk("p2_occ", 32'(occupancy), 32'd3);
    chk("p2_hold_data", 32'(m_data), 32'd1);
    phase_start(); m_ready = 1'b1;
    repeat (12) cycle();
    chk("p2_pops", 32'(n_pop), 32'd8);
    chk("p2_first_pop_cycle", 32'(first_pop), 32'd0);
    chk("p2_span", 32'(last_pop - first_pop), 32'd7);
    chk("p2_first_val", 32'(first_val), 32'd1);

    // Toggling then random m_ready with continuous refill
    phase_start();
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      if (fifo_q.size() < 3) preload(2);
      cycle();
    end
    for (int i = 0; i < 60; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if (fifo_q.size() < 3) preload(2);
      cycle();
    end
    chk("p3_progress", 32'(n_pop > 20), 32'd1);

    // Flush with two buffered words and one in flight
    m_ready = 1'b0; do_reset();
    fifo_q.delete(); next_word = 1; preload(8);
    phase_start();
    for (int i = 0; i < 10 && !(exp_buf.size() == 2 && inflight_m); i++) cycle();
    chk("flush_setup", 32'(exp_buf.size() == 2 && inflight_m), 32'd1);
    cap = fifo_q[0];
    flush = 1'b1; cycle(); flush = 1'b0;
    chk("flush_valid", 32'(m_valid), 32'd0);
    chk("flush_occ", 32'(occupancy), 32'd0);
    phase_start(); m_ready = 1'b1;
    repeat (10) cycle();
    chk("flush_resume", 32'(first_val), 32'(cap));
    chk("flush_resume_val", 32'(first_val), 32'd4);

    // Underflow reported on a landing read
    m_ready = 1'b0; do_reset();
    fifo_q.delete(); next_word = 1; preload(8);
    phase_start();
    force_uf = 1'b1; cycle(); force_uf = 1'b0;
    occ_b = int'(occupancy);
    cycle();
    chk("uf_occ", 32'(occupancy), 32'(occ_b));
    chk("uf_err_set", 32'(underflow_err), 32'd1);
    m_ready = 1'b1;
    repeat (15) cycle();
    chk("uf_first_val", 32'(first_val), 32'd1);
    chk("uf_pops", 32'(n_pop), 32'd8);
    chk("uf_err_sticky", 32'(underflow_err), 32'd1);
    do_reset();
    chk("uf_err_cleared", 32'(underflow_err), 32'd0);

    // Reset mid-stream with two words buffered
    m_ready = 1'b0;
    fifo_q.delete(); next_word = 1; preload(8);
    phase_start();
    for (int i = 0; i < 10 && exp_buf.size() != 2; i++) cycle();
    chk("rst_setup_occ", 32'(occupancy), 32'd2);
    rst_n = 1'b0; cycle();
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_data", 32'(m_data), 32'd0);
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("mid_rst_err", 32'(underflow_err), 32'd0);
    rst_n = 1'b1;
    cap = fifo_q[0];
    phase_start(); m_ready = 1'b1;
    repeat (15) cycle();
    chk("mid_rst_resume", 32'(first_val), 32'(cap));
    chk("mid_rst_pops", 32'(n_pop), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side controller for the team's synchronous FIFO. It issues the FIFO's read strobe and absorbs the FIFO's one-cycle registered read latency. It also re-times the returned words onto a valid/ready stream with full throughput and no combinational ready-to-read path. It sits between the FIFO's `data_out`/`empty`/`underflow` outputs and any downstream consumer.

## Interface
Parameters:
- `FIFO_WIDTH`, 16, word width; must match the FIFO.
- `STAT_WIDTH`, 16, width of the read statistics counter (only used with `FIFO_RD_STATS_EN`).

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_underflow`  in  1  FIFO registered underflow flag.
- `fifo_data_out`  in  FIFO_WIDTH  FIFO registered read data.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `flush`  in  1  synchronous drop of all buffered and in-flight words.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts word.
- `m_data`  out  FIFO_WIDTH  output word.
- `occupancy`  out  2  words held in the internal buffer, 0..3.
- `underflow_err`  out  1  sticky error; set when a landing read reports FIFO underflow.
- `rd_words`  out  STAT_WIDTH  accepted-handshake count; present only with `FIFO_RD_STATS_EN`.

## Operation
- Internal 3-entry circular buffer:
  - write pointer and read pointer wrap 2->0;
  - occupancy counter 0..3.
- `inflight` register is set when `fifo_rd_en` is 1, and marks that a word lands on `fifo_data_out` the next cycle.
- `fifo_rd_en = !fifo_empty && !flush && (occupancy + inflight <= 2)`. It is registered state only; it has no dependence on `m_ready`.
- Land: when `inflight && !fifo_underflow && !flush`, write `fifo_data_out` at the write pointer.
- Land with `fifo_underflow=1`: discard the word and set `underflow_err`. The flag clears only on reset.
- Pop: on `m_valid && m_ready`, advance the read pointer.
- Land and pop in the same cycle: occupancy unchanged, both pointers advance.
- `m_valid = (occupancy != 0)`; `m_data` = entry at the read pointer.
- `flush`:
  - clears occupancy and both pointers next cycle;
  - forces `fifo_rd_en=0`;
  - drops any landing word;
  - does not clear `underflow_err` or `rd_words`.
- Overflow of the buffer is impossible by the credit rule. The verification engineer asserts `occupancy <= 3`.

## Timing
- Reset values:
  - `fifo_rd_en=0`, `m_valid=0`, `m_data=0`;
  - `occupancy=0`, `underflow_err=0`, `rd_words=0`;
  - `inflight=0`, pointers 0.
- Latency from `fifo_rd_en` high in cycle t:
  - `fifo_data_out` valid in t+1;
  - `m_valid` high in t+2.
- Sustained throughput is 1 word/cycle when the FIFO is non-empty and `m_ready=1`.
- Handshake rules:
  - while `m_valid && !m_ready`, `m_data` and `m_valid` hold stable;
  - `m_valid` never drops without a pop or flush.
- `m_ready` low for any duration: reads stop once occupancy + inflight reaches 3, and no word is lost.
- Reset asserted mid-stream: all state returns to reset values on that edge, and an in-flight word is dropped.

## Configuration
- `FIFO_RD_STATS_EN` defined:
  - `rd_words` port exists;
  - it increments on each `m_valid && m_ready`;
  - it saturates at all-ones;
  - reset clears it, flush does not.
- Undefined: the `rd_words` port and counter are absent. All other behaviour is identical.

## Structure
- Package `fifo_rd_pkg`:
  - `BUF_DEPTH = 3`;
  - pointer typedef (2 bits);
  - occupancy typedef (2 bits).
- Sub-module `fifo_rd_buf`: 3-entry circular buffer with pointers, occupancy, push/pop and clear inputs.
- Top level holds the credit/`inflight` logic, the error flag and the stats counter.

## Test plan
- Reset, then FIFO preloaded with 0x0001..0x0008 and `m_ready=1`:
  - `fifo_rd_en` rises the first cycle after reset release;
  - `m_data` presents 0x0001..0x0008 on 8 consecutive cycles, starting 2 cycles after the first read;
  - `rd_words=8` with stats enabled.
- 8 words preloaded, `m_ready=0`:
  - exactly 3 reads issued, `occupancy=3`, `m_data=0x0001` held stable;
  - raising `m_ready` then drains all 8 in order with no gaps.
- `m_ready` toggled 1,0,1,0 with the FIFO continuously refilled: output sequence is strictly in order with no duplicates or drops.
- `flush` pulsed while `occupancy=2` and a read is in flight:
  - next cycle `m_valid=0` and `occupancy=0`;
  - the following words resume from the next FIFO entry.
- `fifo_underflow` forced high on a landing cycle: the word is discarded, `underflow_err=1` stays set until reset, and occupancy does not increase.
- Reset asserted mid-stream with `occupancy=2`: on the next edge all outputs return to reset values, and the stream restarts cleanly after release.
